// File: rtl/instruction_fetch_sequencer_if.sv
// Bundle between the fetch sequencer, its instruction memory and the
// clock control block that consumes the held instruction word.
interface instruction_fetch_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [19:0]       mem_data;
    logic              resume;
    logic [19:0]       ins;
    logic              ins_valid;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    modport master (
        output mem_en, mem_addr, ins, ins_valid, pc, halted,
        input  mem_data, resume
    );

    modport slave (
        input  mem_en, mem_addr, ins, ins_valid, pc, halted,
        output mem_data, resume
    );
endinterface

// File: rtl/instruction_fetch_sequencer.sv
// Fetch-side sequencer: owns the program counter, reads a synchronous
// instruction memory and holds each word stable on ins for a
// class-dependent number of cycles before fetching the next one.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_ISSUE | read strobe to memory at pc (held off until first edge out of reset)
// S_WAIT  | memory data arrives; captured into ins at the closing edge
// S_HOLD  | ins valid, hold counter counts down to 0, then pc advances
// S_HALT  | halt word held; waits for resume, then pc+1
module instruction_fetch_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int HOLD_N   = 5,
    parameter int HOLD_LD  = 6,
    parameter int HOLD_JMP = 7
) (
    input logic                          clk,
    input logic                          rst_n,
    instruction_fetch_sequencer_if.master bus
);
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [19:0]       ins_q, ins_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              armed_q;

    logic              w_halt, w_load, w_jump;
    logic              ins_jump;

    // Word classes; the three patterns never overlap.
    assign w_halt   = (bus.mem_data[19:15] == 5'b10001);
    assign w_load   = (bus.mem_data[19:15] == 5'b10100);
    assign w_jump   = (bus.mem_data[19:17] == 3'b111);
    assign ins_jump = (ins_q[19:17] == 3'b111);

    // armed_q keeps the strobe low while in reset even though the state
    // register already sits in S_ISSUE; the first real fetch is cycle 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed_q <= 1'b0;
        else        armed_q <= 1'b1;
    end

    // State, program counter, held word and hold counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ISSUE;
            pc_q    <= '0;
            ins_q   <= 20'h00000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; ins only ever changes on the S_WAIT closing edge.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_ISSUE: begin
                if (armed_q) state_d = S_WAIT;
            end
            S_WAIT: begin
                ins_d = bus.mem_data;
                if (w_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_HOLD;
                    if (w_jump)      cnt_d = CNT_W'(HOLD_JMP - 1);
                    else if (w_load) cnt_d = CNT_W'(HOLD_LD - 1);
                    else             cnt_d = CNT_W'(HOLD_N - 1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    // Target bits above the address width are dropped.
                    if (ins_jump) pc_d = ins_q[ADDR_W-1:0];
                    else          pc_d = pc_q + ADDR_W'(1);
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HALT: begin
                if (bus.resume) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_ISSUE;
        endcase
    end

    assign bus.mem_en    = armed_q && (state_q == S_ISSUE);
    assign bus.mem_addr  = pc_q;
    assign bus.pc        = pc_q;
    assign bus.ins       = ins_q;
    assign bus.ins_valid = (state_q == S_HOLD) || (state_q == S_HALT);
    assign bus.halted    = (state_q == S_HALT);
endmodule
